// File: rtl/p2s_pkg.sv
// ---------------------------------------------------------------------------
// p2s_pkg
// Shared definitions for the parallel-to-serial converter and its optional
// hold buffer.
//   p2s_state_t          : two-state FSM encoding (IDLE, SHIFT)
//   P2S_DATA_W_DEFAULT   : default parallel word width
//   cnt_w()              : width of the bit counter for a given word width
// ---------------------------------------------------------------------------
package p2s_pkg;

  // FSM encoding shared by the top level and anything that inspects it
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

  localparam int P2S_DATA_W_DEFAULT = 8;

  // One bit wider than strictly needed so DATA_W-1 always fits with headroom
  function automatic int cnt_w(input int dataW);
    return $clog2(dataW) + 1;
  endfunction

endpackage : p2s_pkg

// File: rtl/p2s_hold_buf.sv
// ---------------------------------------------------------------------------
// p2s_hold_buf
// One-entry hold buffer used by parallel_to_serial when the build defines
// P2S_HOLD_BUF_EN. Without that macro this module is not compiled at all.
// Ports:
//   i_clk     : clock, rising edge
//   i_rstn    : asynchronous active-low reset, empties the buffer
//   i_load    : capture i_data and mark the buffer full
//   i_unload  : mark the buffer empty (its word has moved to the shifter)
//   i_data    : word to hold
//   o_data    : held word
//   o_full    : buffer holds a word
// ---------------------------------------------------------------------------
`ifdef P2S_HOLD_BUF_EN
module p2s_hold_buf
  import p2s_pkg::*;
#(
  parameter int DATA_W = P2S_DATA_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_load,
  input  logic              i_unload,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);

  logic [DATA_W-1:0] r_data;
  logic              r_full;

  // Load wins over unload; the top level never asks for both at once
  // because it stops accepting words while the buffer is full.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_load) begin
        r_data <= i_data;
        r_full <= 1'b1;
      end else if (i_unload) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule : p2s_hold_buf
`endif

// File: rtl/parallel_to_serial.sv
// ---------------------------------------------------------------------------
// parallel_to_serial
// Serialises DATA_W-bit words MSB first with a valid/ready input handshake.
// The first bit of an accepted word appears on the cycle after acceptance.
// Build option: define P2S_HOLD_BUF_EN to add a one-entry hold buffer so
// consecutive words stream with no idle gap; otherwise a word is accepted
// only while idle.
// Ports:
//   clk          : clock, rising edge
//   rstn         : asynchronous active-low reset
//   din_parallel : word to serialise, sampled only on acceptance
//   din_valid    : din_parallel is valid
//   din_ready    : word accepted in any cycle with din_valid && din_ready
//   dout_serial  : serial bit (0 whenever dout_valid is low)
//   dout_valid   : dout_serial is valid
//   dout_last    : final bit of the current word
//   busy         : a word is shifting or waiting in the hold buffer
// ---------------------------------------------------------------------------
module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int DATA_W = P2S_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] din_parallel,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout_serial,
  output logic              dout_valid,
  output logic              dout_last,
  output logic              busy
);

  localparam int               CNT_W      = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] PENULT_CNT = CNT_W'(DATA_W - 2);
  localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);

  p2s_state_t        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_bitCnt;
  logic              r_doutValid;
  logic              r_doutLast;
  logic              r_busy;
  logic              r_dinReady;

  logic              w_accept;
  logic              w_lastBit;
  logic              w_loadShifter;
  logic              w_nextShift;
  logic [DATA_W-1:0] w_loadData;

  assign w_accept  = din_valid && r_dinReady;
  assign w_lastBit = (r_state == SHIFT) && (r_bitCnt == LAST_CNT);

`ifdef P2S_HOLD_BUF_EN
  logic              w_bufLoad;
  logic              w_bufUnload;
  logic              w_bufFull;
  logic              w_bufFullNext;
  logic [DATA_W-1:0] w_bufData;

  // A word arriving mid-word parks in the buffer; on the last bit a parked
  // word moves straight into the shifter so its MSB follows with no gap.
  // A word arriving exactly on the last bit with the buffer empty skips the
  // buffer and goes directly into the shifter.
  assign w_bufLoad     = w_accept && (r_state == SHIFT) && !w_lastBit;
  assign w_bufUnload   = w_lastBit && w_bufFull;
  assign w_bufFullNext = (w_bufFull && !w_bufUnload) || w_bufLoad;
  assign w_loadShifter = ((r_state == IDLE) && w_accept) ||
                         (w_lastBit && (w_bufFull || w_accept));
  assign w_loadData    = w_bufUnload ? w_bufData : din_parallel;
  assign w_nextShift   = (r_state == IDLE) ? w_accept
                                           : (!w_lastBit || w_bufFull || w_accept);

  p2s_hold_buf #(
    .DATA_W(DATA_W)
  ) u_holdBuf (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_load  (w_bufLoad),
    .i_unload(w_bufUnload),
    .i_data  (din_parallel),
    .o_data  (w_bufData),
    .o_full  (w_bufFull)
  );
`else
  // Without the buffer, words are only accepted while idle, so there is
  // always at least one idle cycle between consecutive words.
  assign w_loadShifter = (r_state == IDLE) && w_accept;
  assign w_loadData    = din_parallel;
  assign w_nextShift   = (r_state == IDLE) ? w_accept : !w_lastBit;
`endif

  // Single FSM block: state, shifter, counter and every output are
  // registered together. The shifter is cleared whenever no word is in
  // flight so its MSB can drive dout_serial directly and read 0 when idle.
  // din_ready is held low through reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bitCnt    <= '0;
      r_doutValid <= 1'b0;
      r_doutLast  <= 1'b0;
      r_busy      <= 1'b0;
      r_dinReady  <= 1'b0;
    end else begin
      r_state     <= w_nextShift ? SHIFT : IDLE;
      r_doutValid <= w_nextShift;

      if (w_loadShifter) begin
        r_shreg    <= w_loadData;
        r_bitCnt   <= '0;
        r_doutLast <= 1'b0;
      end else if ((r_state == SHIFT) && !w_lastBit) begin
        r_shreg    <= {r_shreg[DATA_W-2:0], 1'b0};
        r_bitCnt   <= r_bitCnt + ONE_CNT;
        r_doutLast <= (r_bitCnt == PENULT_CNT);
      end else begin
        r_shreg    <= '0;
        r_bitCnt   <= '0;
        r_doutLast <= 1'b0;
      end

`ifdef P2S_HOLD_BUF_EN
      r_busy     <= w_nextShift || w_bufFullNext;
      r_dinReady <= !w_bufFullNext;
`else
      r_busy     <= w_nextShift;
      r_dinReady <= !w_nextShift;
`endif
    end
  end

  assign dout_serial = r_shreg[DATA_W-1];
  assign dout_valid  = r_doutValid;
  assign dout_last   = r_doutLast;
  assign busy        = r_busy;
  assign din_ready   = r_dinReady;

endmodule : parallel_to_serial

// File: tb/tb_parallel_to_serial.sv
// ---------------------------------------------------------------------------
// tb_parallel_to_serial
// Directed self-checking bench for parallel_to_serial (DATA_W = 8).
// Define P2S_HOLD_BUF_EN for both bench and RTL to exercise the buffered
// back-to-back stream instead of the gapped one.
// ---------------------------------------------------------------------------
module tb_parallel_to_serial;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [DATA_W-1:0] din;
  logic              dinValid;
  logic              din_ready;
  logic              dout_serial;
  logic              dout_valid;
  logic              dout_last;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Receiver state, owned by the receiver process only
  logic [DATA_W-1:0] rxShift = '0;
  int                rxBits  = 0;
  logic [DATA_W-1:0] rxQ[$];
  int                rxLenQ[$];

  parallel_to_serial #(
    .DATA_W(DATA_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .din_parallel(din),
    .din_valid   (dinValid),
    .din_ready   (din_ready),
    .dout_serial (dout_serial),
    .dout_valid  (dout_valid),
    .dout_last   (dout_last),
    .busy        (busy)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Simple deserialiser: collects valid bits MSB first and records each
  // completed word together with how many bits it took
  always @(negedge clk) begin
    logic [DATA_W-1:0] nextWord;
    if (dout_valid) begin
      nextWord = {rxShift[DATA_W-2:0], dout_serial};
      rxShift <= nextWord;
      if (dout_last) begin
        rxQ.push_back(nextWord);
        rxLenQ.push_back(rxBits + 1);
        rxBits <= 0;
      end else begin
        rxBits <= rxBits + 1;
      end
    end else begin
      rxBits <= 0;
    end
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset values, ready held low in reset, ready rising after release
  task automatic test_reset();
    #12;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout_valid: got %0b expected 0", dout_valid); end
    checks++; if (dout_serial !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout_serial: got %0b expected 0", dout_serial); end
    checks++; if (dout_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout_last: got %0b expected 0", dout_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_din_ready: got %0b expected 0", din_ready); end
    tick();
    checks++; if (din_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_edge: got %0b expected 0", din_ready); end
    rstn = 1'b1;
    #2;
    checks++; if (din_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_ready_pre_edge: got %0b expected 0", din_ready); end
    tick();
    checks++; if (din_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %0b expected 1", din_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL release_busy: got %0b expected 0", busy); end
  endtask

  // 8'hA5 accepted at cycle 0 -> bits 1,0,1,0,0,1,0,1 on cycles 1..8
  task automatic test_single_word();
    logic [DATA_W-1:0] expBits;
    expBits  = 8'b1010_0101;
    din      = 8'hA5;
    dinValid = 1'b1;
    tick();
    dinValid = 1'b0;
    din      = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid c%0d: got %0b expected 1", c, dout_valid); end
      checks++; if (dout_serial !== expBits[8-c]) begin errors++; $display("[TB] FAIL single_bit c%0d: got %0b expected %0b", c, dout_serial, expBits[8-c]); end
      checks++; if (dout_last !== (c == 8)) begin errors++; $display("[TB] FAIL single_last c%0d: got %0b expected %0b", c, dout_last, (c == 8)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy c%0d: got %0b expected 1", c, busy); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %0b expected 0", busy); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_end: got %0b expected 0", dout_valid); end
    checks++; if (dout_serial !== 1'b0) begin errors++; $display("[TB] FAIL single_serial_end: got %0b expected 0", dout_serial); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_end: got %0b expected 1", din_ready); end
  endtask

`ifdef P2S_HOLD_BUF_EN
  // 8'hC3 at cycle 0, 8'h3C at cycle 1 -> 16 contiguous bits on cycles 1..16
  task automatic test_back_to_back();
    logic [15:0] expStream;
    expStream = 16'b1100_0011_0011_1100;
    din       = 8'hC3;
    dinValid  = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid c%0d: got %0b expected 1", c, dout_valid); end
      checks++; if (dout_serial !== expStream[16-c]) begin errors++; $display("[TB] FAIL b2b_bit c%0d: got %0b expected %0b", c, dout_serial, expStream[16-c]); end
      checks++; if (dout_last !== (c == 8 || c == 16)) begin errors++; $display("[TB] FAIL b2b_last c%0d: got %0b expected %0b", c, dout_last, (c == 8 || c == 16)); end
      checks++; if (din_ready !== !(c >= 2 && c <= 8)) begin errors++; $display("[TB] FAIL b2b_ready c%0d: got %0b expected %0b", c, din_ready, !(c >= 2 && c <= 8)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy c%0d: got %0b expected 1", c, busy); end
      if (c == 1) din = 8'h3C;
      if (c == 2) begin dinValid = 1'b0; din = 8'hFF; end
      tick();
    end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid_end: got %0b expected 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end: got %0b expected 0", busy); end
  endtask
`else
  // 8'hFF then 8'h00 with din_valid held: second word waits for one idle cycle
  task automatic test_back_to_back();
    din      = 8'hFF;
    dinValid = 1'b1;
    tick();
    din = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ff_valid c%0d: got %0b expected 1", c, dout_valid); end
      checks++; if (dout_serial !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ff_bit c%0d: got %0b expected 1", c, dout_serial); end
      checks++; if (dout_last !== (c == 8)) begin errors++; $display("[TB] FAIL b2b_ff_last c%0d: got %0b expected %0b", c, dout_last, (c == 8)); end
      checks++; if (din_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ff_ready c%0d: got %0b expected 0", c, din_ready); end
      tick();
    end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap_valid: got %0b expected 0", dout_valid); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gap_ready: got %0b expected 1", din_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap_busy: got %0b expected 0", busy); end
    tick();
    dinValid = 1'b0;
    for (int c = 10; c <= 17; c++) begin
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_00_valid c%0d: got %0b expected 1", c, dout_valid); end
      checks++; if (dout_serial !== 1'b0) begin errors++; $display("[TB] FAIL b2b_00_bit c%0d: got %0b expected 0", c, dout_serial); end
      checks++; if (dout_last !== (c == 17)) begin errors++; $display("[TB] FAIL b2b_00_last c%0d: got %0b expected %0b", c, dout_last, (c == 17)); end
      tick();
    end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid_end: got %0b expected 0", dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end: got %0b expected 0", busy); end
  endtask
`endif

  // 8'h81 accepted, then din_parallel changes while the word is in flight
  task automatic test_input_change();
    logic [DATA_W-1:0] expBits;
    expBits  = 8'b1000_0001;
    din      = 8'h81;
    dinValid = 1'b1;
    tick();
    dinValid = 1'b0;
    din      = 8'h7E;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (dout_serial !== expBits[8-c]) begin errors++; $display("[TB] FAIL inchg_bit c%0d: got %0b expected %0b", c, dout_serial, expBits[8-c]); end
      if (c == 4) din = 8'h55;
      tick();
    end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL inchg_valid_end: got %0b expected 0", dout_valid); end
  endtask

  // 8'hF0 in flight, reset at cycle 4: outputs clear at once, nothing after
  task automatic test_reset_mid_word();
    din      = 8'hF0;
    dinValid = 1'b1;
    tick();
    dinValid = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (dout_serial !== 1'b1 || dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre: got serial %0b valid %0b expected 1 1", dout_serial, dout_valid); end
    rstn = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %0b expected 0", dout_valid); end
    checks++; if (dout_serial !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_serial: got %0b expected 0", dout_serial); end
    checks++; if (dout_last !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_last: got %0b expected 0", dout_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %0b expected 0", busy); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ready: got %0b expected 0", din_ready); end
    tick();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if (dout_valid !== 1'b0 || dout_serial !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after c%0d: got valid %0b serial %0b expected 0 0", c, dout_valid, dout_serial); end
    end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready_end: got %0b expected 1", din_ready); end
  endtask

  // 1000 random words, source holds each until accepted, occasional gaps;
  // the receiver must see every word in order with exactly DATA_W bits
  task automatic test_round_trip();
    logic [DATA_W-1:0] txQ[$];
    logic [DATA_W-1:0] word;
    int                guard;
    int                n;
    rxQ.delete();
    rxLenQ.delete();
    for (int k = 0; k < 1000; k++) begin
      word = 8'($urandom_range(0, 255));
      txQ.push_back(word);
      din      = word;
      dinValid = 1'b1;
      guard    = 0;
      while (!din_ready && guard < 40) begin
        tick();
        guard++;
      end
      if (guard >= 40) begin
        checks++; errors++;
        $display("[TB] FAIL rt_ready_timeout word %0d: got ready 0 expected 1 within 40 cycles", k);
        break;
      end
      tick();
      if ($urandom_range(0, 3) == 0) begin
        dinValid = 1'b0;
        tick();
      end
    end
    dinValid = 1'b0;
    guard    = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rt_drain: got busy %0b expected 0", busy); end
    tick();
    tick();
    checks++; if (rxQ.size() != txQ.size()) begin errors++; $display("[TB] FAIL rt_count: got %0d words expected %0d", rxQ.size(), txQ.size()); end
    n = (rxQ.size() < txQ.size()) ? rxQ.size() : txQ.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (rxQ[i] !== txQ[i]) begin errors++; $display("[TB] FAIL rt_word %0d: got %02h expected %02h", i, rxQ[i], txQ[i]); end
      checks++; if (rxLenQ[i] != DATA_W) begin errors++; $display("[TB] FAIL rt_len %0d: got %0d bits expected %0d", i, rxLenQ[i], DATA_W); end
    end
  endtask

  // Scenarios run in order; each leaves the DUT idle and ready
  initial begin
    rstn     = 1'b0;
    din      = '0;
    dinValid = 1'b0;
    $display("[TB] start");
    test_reset();
    test_single_word();
    test_back_to_back();
    test_input_change();
    test_reset_mid_word();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_parallel_to_serial
